// File: rtl/rand_range_sampler.sv
// Draws a number in 1..RANGE_MAX from a 6-bit LFSR by rejection sampling.
// The result is shown as two active-low seven-segment BCD digits; an all-zero LFSR is flagged.
module rand_range_sampler #(
    parameter int RANGE_MAX = 36,
    parameter int SKIP      = 6,
    parameter int MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] rnd_in,
    input  logic       lfsr_enable,
    input  logic       req,
    output logic       busy,
    output logic       valid,
    output logic [5:0] value,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       zero_err
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SKIP    = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_REDUCE  = 3'd3;
    localparam logic [2:0] ST_CONVERT = 3'd4;

    localparam logic [5:0] RMAX      = 6'(RANGE_MAX);
    localparam logic [5:0] SKIP_INIT = 6'(SKIP - 1);
    localparam logic [5:0] TEN       = 6'd10;
    localparam logic [8:0] TRY_LIMIT = 9'(MAX_TRIES);
    localparam logic [6:0] BLANK     = 7'b1111111;

    logic [2:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] tries_q, tries_d;
    logic [5:0] rem_q, rem_d;
    logic [2:0] tens_q, tens_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;
    logic       zero_err_q, zero_err_d;
    logic [5:0] value_q, value_d;
    logic [3:0] bcd_tens_q, bcd_tens_d;
    logic [3:0] bcd_ones_q, bcd_ones_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tries_d    = tries_q;
        rem_d      = rem_q;
        tens_d     = tens_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        zero_err_d = zero_err_q;
        value_d    = value_q;
        bcd_tens_d = bcd_tens_q;
        bcd_ones_d = bcd_ones_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d    = ST_SKIP;
                    cnt_d      = SKIP_INIT;
                    tries_d    = 8'd0;
                    busy_d     = 1'b1;
                    valid_d    = 1'b0;
                    zero_err_d = 1'b0;
                end
            end
            ST_SKIP: begin
                // While a seed is being shifted in, rnd_in is not random: stall.
                if (!lfsr_enable) begin
                    if (cnt_q == 6'd0) state_d = ST_CHECK;
                    else               cnt_d   = cnt_q - 6'd1;
                end
            end
            ST_CHECK: begin
                if (!lfsr_enable) begin
                    if (rnd_in == 6'd0) begin
                        zero_err_d = 1'b1;
                        busy_d     = 1'b0;
                        valid_d    = 1'b0;
                        state_d    = ST_IDLE;
                    end else if (rnd_in <= RMAX) begin
                        rem_d   = rnd_in;
                        tens_d  = 3'd0;
                        state_d = ST_CONVERT;
                    end else if ({1'b0, tries_q} + 9'd1 < TRY_LIMIT) begin
                        tries_d = tries_q + 8'd1;
                        cnt_d   = SKIP_INIT;
                        state_d = ST_SKIP;
                    end else begin
                        rem_d   = rnd_in;
                        state_d = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                if (rem_q > RMAX) begin
                    rem_d = rem_q - RMAX;
                end else begin
                    tens_d  = 3'd0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                // Binary to BCD by repeated subtraction of ten.
                if (rem_q >= TEN) begin
                    rem_d  = rem_q - TEN;
                    tens_d = tens_q + 3'd1;
                end else begin
                    bcd_tens_d = {1'b0, tens_q};
                    bcd_ones_d = rem_q[3:0];
                    value_d    = {3'd0, tens_q} * TEN + rem_q;
                    valid_d    = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            tries_q    <= 8'd0;
            rem_q      <= 6'd0;
            tens_q     <= 3'd0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            zero_err_q <= 1'b0;
            value_q    <= 6'd0;
            bcd_tens_q <= 4'd0;
            bcd_ones_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            rem_q      <= rem_d;
            tens_q     <= tens_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            zero_err_q <= zero_err_d;
            value_q    <= value_d;
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    // Segments decode straight from registered digits, so reset blanks them at once.
    assign seg_ones = valid_q ? seg_decode(bcd_ones_q) : BLANK;
    assign seg_tens = (valid_q && bcd_tens_q != 4'd0) ? seg_decode(bcd_tens_q) : BLANK;

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign value    = value_q;
    assign bcd_tens = bcd_tens_q;
    assign bcd_ones = bcd_ones_q;
    assign zero_err = zero_err_q;

endmodule
